// File: rtl/argmax_layer.sv
// argmax_layer: per-row argmax over N rows of CHAR_NUM signed logits.
// Each row is scanned PAR elements per cycle over STEPS cycles. The scan
// returns the row maximum and the lowest index that holds it. The maxima
// feed softmax_layer d_max; the indices are the predicted chars (d_num).
//
// Ports
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   run    : start pulse, accepted in IDLE/DONE, ignored during SCAN;
//            d must be held stable until valid
//   d      : logits, element j of row i at [(i*CHAR_NUM+j)*N_LEN +: N_LEN]
//   valid  : results ready; held until the next accepted run
//   q_max  : row maxima, row i at [i*N_LEN +: N_LEN]
//   q_num  : argmax indices, row i at [i*CHAR_LEN +: CHAR_LEN]
//
// state | meaning
// IDLE  | after reset, no result yet
// SCAN  | chunks 1..STEPS-1 being folded into the running max/index
// DONE  | q_max/q_num valid, waiting for the next run
module argmax_layer #(
  parameter int N        = 8,
  parameter int CHAR_NUM = 200,
  parameter int N_LEN    = 16,
  parameter int CHAR_LEN = 8,
  parameter int PAR      = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         run,
  input  logic [N*CHAR_NUM*N_LEN-1:0]  d,
  output logic                         valid,
  output logic [N*N_LEN-1:0]           q_max,
  output logic [N*CHAR_LEN-1:0]        q_num
);
  localparam int STEPS = (CHAR_NUM + PAR - 1) / PAR;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [CW-1:0] chunk;
  logic          accept, last;

  logic signed [N_LEN-1:0] run_max   [N];
  logic [CHAR_LEN-1:0]     run_idx   [N];
  logic signed [N_LEN-1:0] chunk_max [N];
  logic [CHAR_LEN-1:0]     chunk_idx [N];
  logic signed [N_LEN-1:0] new_max   [N];
  logic [CHAR_LEN-1:0]     new_idx   [N];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // The accepting edge already consumes chunk 0, so SCAN starts at cnt=1.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    last      = 1'b0;
    chunk     = cnt;
    case (state)
      IDLE, DONE: begin
        if (run) begin
          accept = 1'b1;
          chunk  = '0;
          if (STEPS == 1) begin
            last      = 1'b1;
            state_nxt = DONE;
            cnt_nxt   = '0;
          end else begin
            state_nxt = SCAN;
            cnt_nxt   = CW'(1);
          end
        end
      end
      SCAN: begin
        if (cnt == CW'(STEPS - 1)) begin
          last      = 1'b1;
          state_nxt = DONE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Lanes are visited in ascending index order and replace only on strict >,
  // so equal values keep the lower index. Lane 0 of any chunk is always a real
  // element; lanes past CHAR_NUM are never read (they would alias the next row).
  always_comb begin
    int                      e;
    logic signed [N_LEN-1:0] v;
    for (int i = 0; i < N; i++) begin
      chunk_max[i] = '0;
      chunk_idx[i] = '0;
      for (int j = 0; j < PAR; j++) begin
        e = int'(chunk) * PAR + j;
        v = '0;
        if (e < CHAR_NUM) begin
          v = d[(i*CHAR_NUM + e)*N_LEN +: N_LEN];
          if (j == 0 || v > chunk_max[i]) begin
            chunk_max[i] = v;
            chunk_idx[i] = CHAR_LEN'(e);
          end
        end
      end
      if (accept || chunk_max[i] > run_max[i]) begin
        new_max[i] = chunk_max[i];
        new_idx[i] = chunk_idx[i];
      end else begin
        new_max[i] = run_max[i];
        new_idx[i] = run_idx[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      q_max <= '0;
      q_num <= '0;
      for (int i = 0; i < N; i++) begin
        run_max[i] <= '0;
        run_idx[i] <= '0;
      end
    end else begin
      if (accept || state == SCAN) begin
        for (int i = 0; i < N; i++) begin
          run_max[i] <= new_max[i];
          run_idx[i] <= new_idx[i];
        end
      end
      if (accept) valid <= 1'b0;
      if (last) begin
        valid <= 1'b1;
        for (int i = 0; i < N; i++) begin
          q_max[i*N_LEN +: N_LEN]       <= new_max[i];
          q_num[i*CHAR_LEN +: CHAR_LEN] <= new_idx[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_argmax_layer.sv
module tb_argmax_layer;
  localparam int N   = 8;
  localparam int CN  = 200;
  localparam int NL  = 16;
  localparam int CL  = 8;
  localparam int PAR = 8;
  localparam int CN2 = 13;
  localparam int DW  = N*CN*NL;
  localparam int DW2 = N*CN2*NL;
  localparam int MW  = N*NL;
  localparam int IW  = N*CL;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          run = 1'b0;
  logic [DW-1:0] d = '0;
  logic          valid;
  logic [MW-1:0] q_max;
  logic [IW-1:0] q_num;

  logic           run2 = 1'b0;
  logic [DW2-1:0] d2 = '0;
  logic           valid2;
  logic [MW-1:0]  q_max2;
  logic [IW-1:0]  q_num2;

  int n_pass = 0;
  int n_total = 0;

  logic [MW-1:0] exp_max_q[$];
  logic [IW-1:0] exp_num_q[$];
  logic          valid_d = 1'b0;

  argmax_layer #(.N(N), .CHAR_NUM(CN), .N_LEN(NL), .CHAR_LEN(CL), .PAR(PAR)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .d(d),
    .valid(valid), .q_max(q_max), .q_num(q_num));

  argmax_layer #(.N(N), .CHAR_NUM(CN2), .N_LEN(NL), .CHAR_LEN(CL), .PAR(PAR)) dut_pad (
    .clk(clk), .rst_n(rst_n), .run(run2), .d(d2),
    .valid(valid2), .q_max(q_max2), .q_num(q_num2));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference: find the row maximum first, then the first position holding it.
  function automatic void ref_argmax(input logic [DW-1:0] dv,
                                     output logic [MW-1:0] em, output logic [IW-1:0] ei);
    int vals[CN];
    int best;
    int idx;
    em = '0;
    ei = '0;
    for (int r = 0; r < N; r++) begin
      best = -100000;
      idx  = 0;
      for (int e = 0; e < CN; e++) begin
        vals[e] = int'($signed(dv[(r*CN + e)*NL +: NL]));
        if (vals[e] > best) best = vals[e];
      end
      for (int e = CN-1; e >= 0; e--) if (vals[e] == best) idx = e;
      em[r*NL +: NL] = 16'(best);
      ei[r*CL +: CL] = 8'(idx);
    end
  endfunction

  function automatic logic [DW-1:0] fill(input logic [15:0] x);
    logic [DW-1:0] v;
    for (int k = 0; k < N*CN; k++) v[k*NL +: NL] = x;
    return v;
  endfunction

  function automatic logic [DW-1:0] set_el(input logic [DW-1:0] v, input int r, input int e,
                                           input logic [15:0] x);
    v[(r*CN + e)*NL +: NL] = x;
    return v;
  endfunction

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic issue_run(input logic [DW-1:0] dv);
    logic [MW-1:0] em;
    logic [IW-1:0] ei;
    d   = dv;
    run = 1'b1;
    ref_argmax(dv, em, ei);
    exp_max_q.push_back(em);
    exp_num_q.push_back(ei);
    @(negedge clk);
    run = 1'b0;
  endtask

  task automatic wait_valid(input int start, output int n);
    n = start;
    while (!valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!valid) begin
      n_total++;
      $display("FAIL valid_timeout: valid still %0d after %0d edges, required 1", valid, n);
    end
  endtask

  // Scoreboard monitor: every rising valid retires the oldest expectation.
  always @(negedge clk) begin
    logic [MW-1:0] em;
    logic [IW-1:0] ei;
    if (rst_n && valid && !valid_d) begin
      if (exp_num_q.size() == 0) begin
        n_total++;
        $display("FAIL sb_empty: valid rose with q_num %h, no result required", q_num);
      end else begin
        em = exp_max_q.pop_front();
        ei = exp_num_q.pop_front();
        chk("sb_q_max", 128'(q_max), 128'(em));
        chk("sb_q_num", 128'(q_num), 128'(ei));
      end
    end
    valid_d = valid;
  end

  initial begin
    #4000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] dv;
    logic [MW-1:0] em, old_m;
    logic [IW-1:0] ei, old_n;
    int n, x;

    #1;
    chk("reset_valid", 128'(valid), 128'(0));
    chk("reset_q_max", 128'(q_max), 128'(0));
    chk("reset_q_num", 128'(q_num), 128'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // basic: single +100 peak per row on a -5 floor
    dv = fill(16'hFFFB);
    for (int i = 0; i < N; i++) dv = set_el(dv, i, 37 + i, 16'd100);
    issue_run(dv);
    chk("basic_valid_low_after_accept", 128'(valid), 128'(0));
    wait_valid(1, n);
    chk("basic_latency", 128'(n), 128'(25));
    for (int i = 0; i < N; i++) begin
      em[i*NL +: NL] = 16'd100;
      ei[i*CL +: CL] = 8'(37 + i);
    end
    chk("basic_q_max", 128'(q_max), 128'(em));
    chk("basic_q_num", 128'(q_num), 128'(ei));

    // reset in the middle of a scan
    issue_run(fill(16'd9));
    repeat (8) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midscan_reset_valid", 128'(valid), 128'(0));
    chk("midscan_reset_q_max", 128'(q_max), 128'(0));
    chk("midscan_reset_q_num", 128'(q_num), 128'(0));
    exp_max_q.delete();
    exp_num_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    chk("reset_stays_idle", 128'(valid), 128'(0));

    // ties and sign
    dv = '0;
    for (int k = 0; k < N*CN; k++) dv[k*NL +: NL] = 16'($urandom);
    for (int e = 0; e < CN; e++) begin
      dv = set_el(dv, 0, e, 16'h8000);
      dv = set_el(dv, 1, e, 16'hFFFF);
      x  = int'($urandom_range(0, 200)) - 100;
      dv = set_el(dv, 2, e, 16'(x));
    end
    dv = set_el(dv, 1, 3, 16'd300);
    dv = set_el(dv, 1, 150, 16'd300);
    dv = set_el(dv, 2, 199, 16'd500);
    issue_run(dv);
    wait_valid(1, n);
    chk("tie_allneg_num", 128'(q_num[0*CL +: CL]), 128'(0));
    chk("tie_allneg_max", 128'(q_max[0*NL +: NL]), 128'(16'h8000));
    chk("tie_low_index", 128'(q_num[1*CL +: CL]), 128'(3));
    chk("tie_low_max", 128'(q_max[1*NL +: NL]), 128'(300));
    chk("last_elem_num", 128'(q_num[2*CL +: CL]), 128'(199));
    chk("last_elem_max", 128'(q_max[2*NL +: NL]), 128'(500));

    // handshake: runs during SCAN are ignored
    dv = '0;
    for (int k = 0; k < N*CN; k++) dv[k*NL +: NL] = 16'($urandom);
    issue_run(dv);
    repeat (3) @(negedge clk);
    run = 1'b1;
    @(negedge clk);
    run = 1'b0;
    repeat (4) @(negedge clk);
    run = 1'b1;
    @(negedge clk);
    run = 1'b0;
    wait_valid(10, n);
    chk("ignored_run_latency", 128'(n), 128'(25));

    // run in DONE: valid falls, old q held until the new result
    old_m = q_max;
    old_n = q_num;
    dv = '0;
    for (int k = 0; k < N*CN; k++) dv[k*NL +: NL] = 16'($urandom);
    issue_run(dv);
    chk("done_run_valid_drop", 128'(valid), 128'(0));
    chk("done_run_q_num_held", 128'(q_num), 128'(old_n));
    repeat (10) @(negedge clk);
    chk("scan_q_max_stable", 128'(q_max), 128'(old_m));
    chk("scan_q_num_stable", 128'(q_num), 128'(old_n));
    wait_valid(11, n);
    chk("done_run_latency", 128'(n), 128'(25));

    // padded build: CHAR_NUM=13 leaves lanes 13..15 of chunk 1 empty
    for (int k = 0; k < N*CN2; k++) d2[k*NL +: NL] = 16'hFFFF;
    for (int i = 0; i < N; i++) d2[(i*CN2 + 12)*NL +: NL] = 16'hFFFE;
    d2[(1*CN2 + 0)*NL +: NL] = 16'd7;
    run2 = 1'b1;
    @(negedge clk);
    run2 = 1'b0;
    chk("pad_valid_after_1", 128'(valid2), 128'(0));
    @(negedge clk);
    chk("pad_valid_after_2", 128'(valid2), 128'(1));
    em = {N{16'hFFFF}};
    em[1*NL +: NL] = 16'd7;
    chk("pad_q_num", 128'(q_num2), 128'(0));
    chk("pad_q_max", 128'(q_max2), 128'(em));

    // random back-to-back runs
    for (int v = 0; v < 200; v++) begin
      dv = '0;
      for (int k = 0; k < N*CN; k++) begin
        if (v % 2 == 0) begin
          x = int'($urandom_range(0, 7)) - 4;
          dv[k*NL +: NL] = 16'(x);
        end else begin
          dv[k*NL +: NL] = 16'($urandom);
        end
      end
      issue_run(dv);
      wait_valid(1, n);
    end
    @(negedge clk);
    chk("sb_drained", 128'(exp_num_q.size()), 128'(0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
